// File: rtl/tiny_dnn_layer_seq.sv
// Layer sequencer: queues packed layer descriptors, issues one layer at a time to the execution controller.
// Latency: descriptor pop -> s_init next cycle; s_fin -> layer_done next cycle -> next s_init the cycle after.
// Backpressure: cmd_ready low while the command FIFO is full (a same-cycle pop does not free the slot).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   en                       sequencing enable (gates popping of new layers)
//   cmd_valid/cmd_ready/cmd_data  descriptor push interface, 83-bit packed descriptor
//   err_clr                  clears the sticky timeout flag
//   s_fin / s_init / run     handshake with the execution controller
//   backprop..kw             latched layer geometry, held stable for the whole layer
//   busy, layer_done, all_done, layer_cnt, timeout, fifo_cnt  host status
module tiny_dnn_layer_seq #(
  parameter int DEPTH = 4,
  parameter int TMO_W = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [82:0]                cmd_data,
  input  logic                       err_clr,
  input  logic                       s_fin,
  output logic                       s_init,
  output logic                       run,
  output logic                       backprop,
  output logic [3:0]                 dd,
  output logic [3:0]                 id,
  output logic [9:0]                 is,
  output logic [4:0]                 ih,
  output logic [4:0]                 iw,
  output logic [3:0]                 od,
  output logic [9:0]                 os,
  output logic [4:0]                 oh,
  output logic [4:0]                 ow,
  output logic [9:0]                 fs,
  output logic [9:0]                 ks,
  output logic [4:0]                 kh,
  output logic [4:0]                 kw,
  output logic                       busy,
  output logic                       layer_done,
  output logic                       all_done,
  output logic [7:0]                 layer_cnt,
  output logic                       timeout,
  output logic [$clog2(DEPTH):0]     fifo_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  // Watchdog value in the cycle whose edge would make it all-ones.
  localparam logic [TMO_W-1:0] WD_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
  localparam logic [TMO_W-1:0] WD_MAX  = {TMO_W{1'b1}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_NEXT = 2'd3;

  logic [82:0]      mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [1:0]       state;
  logic [TMO_W-1:0] wdog;
  logic [82:0]      cfg;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             wd_fire;

  // Extra pointer bit distinguishes full from empty; difference is occupancy.
  assign fifo_cnt  = wr_ptr - rd_ptr;
  assign full      = (fifo_cnt == FULL_CNT);
  assign empty     = (fifo_cnt == '0);
  assign cmd_ready = !full && !rst;
  assign push      = cmd_valid && cmd_ready;

  // s_fin on the last watchdog cycle still counts as a normal completion.
  assign wd_fire = (state == S_RUN) && !s_fin && (wdog == WD_LAST);

  always_comb begin
    pop = 1'b0;
    if (state == S_IDLE)
      pop = en && !empty && !timeout;
    else if (state == S_NEXT)
      pop = en && !empty;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr[AW-1:0]] <= cmd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      state     <= S_IDLE;
      wdog      <= '0;
      cfg       <= '0;
      timeout   <= 1'b0;
      layer_cnt <= 8'd0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;

      // Flush drops everything queued so far; a same-cycle push survives
      // because rd lands on the slot that push is writing.
      if (wd_fire)
        rd_ptr <= wr_ptr;
      else if (pop)
        rd_ptr <= rd_ptr + 1'b1;

      if (pop)
        cfg <= mem[rd_ptr[AW-1:0]];

      if (err_clr)
        timeout <= 1'b0;
      else if (wd_fire)
        timeout <= 1'b1;

      case (state)
        S_IDLE: begin
          if (pop)
            state <= S_INIT;
        end
        S_INIT: begin
          wdog  <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          if (wdog != WD_MAX)
            wdog <= wdog + 1'b1;
          if (s_fin)
            state <= S_NEXT;
          else if (wd_fire)
            state <= S_IDLE;
        end
        default: begin
          layer_cnt <= layer_cnt + 8'd1;
          state     <= pop ? S_INIT : S_IDLE;
        end
      endcase
    end
  end

  assign s_init     = (state == S_INIT);
  assign run        = (state == S_INIT) || (state == S_RUN);
  assign busy       = (state != S_IDLE);
  assign layer_done = (state == S_NEXT);
  // A pop never happens with the FIFO empty, so empty here means we return to IDLE.
  assign all_done   = (state == S_NEXT) && empty;

  assign backprop = cfg[82];
  assign dd       = cfg[81:78];
  assign id       = cfg[77:74];
  assign is       = cfg[73:64];
  assign ih       = cfg[63:59];
  assign iw       = cfg[58:54];
  assign od       = cfg[53:50];
  assign os       = cfg[49:40];
  assign oh       = cfg[39:35];
  assign ow       = cfg[34:30];
  assign fs       = cfg[29:20];
  assign ks       = cfg[19:10];
  assign kh       = cfg[9:5];
  assign kw       = cfg[4:0];

endmodule

// File: tb/tb_tiny_dnn_layer_seq.sv
// Testbench for tiny_dnn_layer_seq: directed stimulus, config scoreboard checked on every s_init.
// Latency checks are cycle-exact relative to s_init / s_fin.
// Host push side stalls on cmd_ready; execution-controller side is modelled by driving s_fin.
module tb_tiny_dnn_layer_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [82:0] cmd_data;
  logic        err_clr;
  logic        s_fin;
  logic        s_init;
  logic        run;
  logic        backprop;
  logic [3:0]  dd, id, od;
  logic [9:0]  is, os, fs, ks;
  logic [4:0]  ih, iw, oh, ow, kh, kw;
  logic        busy;
  logic        layer_done;
  logic        all_done;
  logic [7:0]  layer_cnt;
  logic        timeout;
  logic [2:0]  fifo_cnt;

  tiny_dnn_layer_seq #(.DEPTH(4), .TMO_W(4)) dut (
    .clk(clk), .rst(rst), .en(en),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .err_clr(err_clr), .s_fin(s_fin), .s_init(s_init), .run(run),
    .backprop(backprop), .dd(dd), .id(id), .is(is), .ih(ih), .iw(iw),
    .od(od), .os(os), .oh(oh), .ow(ow), .fs(fs), .ks(ks), .kh(kh), .kw(kw),
    .busy(busy), .layer_done(layer_done), .all_done(all_done),
    .layer_cnt(layer_cnt), .timeout(timeout), .fifo_cnt(fifo_cnt)
  );

  always #5 clk = ~clk;

  logic [82:0] cfg_o;
  assign cfg_o = {backprop, dd, id, is, ih, iw, od, os, oh, ow, fs, ks, kh, kw};

  int tests = 0;
  int fails = 0;
  int ld_cnt = 0;
  int ad_cnt = 0;
  logic [82:0] exp_q[$];

  task automatic chkn(input string name, input logic [82:0] act, input logic [82:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Descriptor with the four named fields set explicitly; the rest derive from tag.
  function automatic logic [82:0] mkd(input logic bp, input logic [3:0] d,
                                      input logic [4:0] h, input logic [4:0] w,
                                      input logic [7:0] tag);
    logic [4:0] t5;
    logic [4:0] t5n;
    logic [4:0] t5x;
    logic [4:0] t5p;
    t5  = tag[4:0];
    t5n = ~tag[4:0];
    t5x = tag[4:0] ^ 5'h0a;
    t5p = tag[4:0] + 5'd1;
    return {bp, d, tag[3:0], {2'b00, tag}, t5, t5n, tag[7:4], {tag, 2'b01},
            h, t5x, {2'b10, tag}, {tag, 2'b11}, t5p, w};
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [82:0] d, input bit expect_run);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_data  = d;
    if (expect_run)
      exp_q.push_back(d);
    while (!cmd_ready && n < 40) begin
      cyc;
      n++;
    end
    chk1("push_accepted", cmd_ready, 1'b1);
    cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_sinit;
    int n;
    n = 0;
    while (!s_init && n < 30) begin
      cyc;
      n++;
    end
    chk1("s_init_seen", s_init, 1'b1);
  endtask

  // Called in the INIT cycle; raises s_fin in RUN cycle n_run, returns in NEXT.
  task automatic fin_layer(input int n_run, input logic exp_all);
    repeat (n_run) cyc;
    chk1("run_before_fin", run, 1'b1);
    s_fin = 1'b1;
    cyc;
    s_fin = 1'b0;
    chk1("layer_done", layer_done, 1'b1);
    chk1("all_done", all_done, exp_all);
  endtask

  task automatic do_layer(input int n_run, input logic exp_all);
    wait_sinit;
    fin_layer(n_run, exp_all);
  endtask

  // Monitor: every s_init must be one cycle wide and carry the next expected descriptor.
  initial begin
    logic prev_init;
    logic [82:0] e;
    prev_init = 1'b0;
    forever begin
      @(negedge clk);
      if (layer_done === 1'b1) ld_cnt++;
      if (all_done === 1'b1) ad_cnt++;
      if (s_init === 1'b1) begin
        chk1("s_init_width", prev_init, 1'b0);
        if (exp_q.size() == 0) begin
          chk1("unexpected_s_init", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chkn("cfg_at_init", cfg_o, e);
        end
      end
      prev_init = (s_init === 1'b1);
    end
  end

  initial begin
    #300000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [82:0] d1;
    logic [82:0] dq[5];
    int ld0;
    int ad0;

    rst = 1'b1; en = 1'b0; cmd_valid = 1'b0; cmd_data = '0;
    err_clr = 1'b0; s_fin = 1'b0;
    cyc;
    cyc;
    chk1("ready_in_rst", cmd_ready, 1'b0);
    chk1("busy_in_rst", busy, 1'b0);
    rst = 1'b0;
    cyc;
    chk1("ready_after_rst", cmd_ready, 1'b1);
    chkn("fifo_cnt_rst", 83'(fifo_cnt), 83'(0));
    chkn("layer_cnt_rst", 83'(layer_cnt), 83'(0));
    chkn("cfg_rst", cfg_o, 83'(0));
    chk1("timeout_rst", timeout, 1'b0);
    chk1("run_rst", run, 1'b0);

    // Single layer.
    d1 = mkd(1'b1, 4'd2, 5'd3, 5'd2, 8'h11);
    en = 1'b1;
    push(d1, 1'b1);
    wait_sinit;
    chk1("run_in_init", run, 1'b1);
    chkn("dd", 83'(dd), 83'(2));
    chkn("oh", 83'(oh), 83'(3));
    chkn("kw", 83'(kw), 83'(2));
    chk1("backprop", backprop, 1'b1);
    fin_layer(10, 1'b1);
    chkn("cfg_hold", cfg_o, d1);
    cyc;
    chk1("busy_after_single", busy, 1'b0);
    chkn("layer_cnt_single", 83'(layer_cnt), 83'(1));

    // Back-to-back: three queued layers.
    en = 1'b0;
    for (int i = 0; i < 3; i++) push(mkd(i[0], 4'(i + 5), 5'(i + 7), 5'(i + 9), 8'(8'h20 + i)), 1'b1);
    chkn("fifo_cnt_three", 83'(fifo_cnt), 83'(3));
    en = 1'b1;
    do_layer(3, 1'b0);
    cyc;
    chk1("b2b_gap_1", s_init, 1'b1);
    do_layer(2, 1'b0);
    cyc;
    chk1("b2b_gap_2", s_init, 1'b1);
    do_layer(4, 1'b1);
    cyc;
    chkn("layer_cnt_b2b", 83'(layer_cnt), 83'(4));
    chkn("all_done_total", 83'(ad_cnt), 83'(2));
    chkn("layer_done_total", 83'(ld_cnt), 83'(4));

    // FIFO full: fifth push held until the first pop.
    en = 1'b0;
    for (int i = 0; i < 5; i++) dq[i] = mkd(1'b0, 4'(i), 5'(i + 1), 5'(i + 2), 8'(8'h40 + i));
    for (int i = 0; i < 4; i++) push(dq[i], 1'b1);
    chkn("fifo_cnt_full", 83'(fifo_cnt), 83'(4));
    chk1("ready_full", cmd_ready, 1'b0);
    cmd_valid = 1'b1;
    cmd_data  = dq[4];
    exp_q.push_back(dq[4]);
    repeat (3) cyc;
    chk1("ready_still_full", cmd_ready, 1'b0);
    chkn("fifo_cnt_held", 83'(fifo_cnt), 83'(4));
    en = 1'b1;
    cyc;
    chk1("full_first_init", s_init, 1'b1);
    chkn("fifo_cnt_after_pop", 83'(fifo_cnt), 83'(3));
    chk1("ready_after_pop", cmd_ready, 1'b1);
    cyc;
    cmd_valid = 1'b0;
    chkn("fifo_cnt_fifth_in", 83'(fifo_cnt), 83'(4));
    s_fin = 1'b1;
    cyc;
    s_fin = 1'b0;
    chk1("full_first_done", layer_done, 1'b1);
    for (int i = 0; i < 4; i++) do_layer(1 + i, (i == 3) ? 1'b1 : 1'b0);
    cyc;
    chkn("fifo_cnt_drained", 83'(fifo_cnt), 83'(0));
    chkn("layer_cnt_full", 83'(layer_cnt), 83'(9));

    // Watchdog: no s_fin, queued entries flushed.
    push(mkd(1'b1, 4'd9, 5'd9, 5'd9, 8'h60), 1'b1);
    wait_sinit;
    push(mkd(1'b0, 4'd1, 5'd1, 5'd1, 8'h61), 1'b0);
    push(mkd(1'b0, 4'd2, 5'd2, 5'd2, 8'h62), 1'b0);
    chkn("fifo_cnt_wd_queued", 83'(fifo_cnt), 83'(2));
    ld0 = ld_cnt;
    repeat (13) cyc;
    chk1("wd_run_15", run, 1'b1);
    chk1("wd_not_yet", timeout, 1'b0);
    cyc;
    chk1("wd_timeout", timeout, 1'b1);
    chkn("wd_flushed", 83'(fifo_cnt), 83'(0));
    chk1("wd_busy", busy, 1'b0);
    chk1("wd_no_layer_done", layer_done, 1'b0);
    push(mkd(1'b1, 4'd3, 5'd4, 5'd5, 8'h63), 1'b1);
    cyc;
    chkn("wd_push_kept", 83'(fifo_cnt), 83'(1));
    chk1("wd_blocked", busy, 1'b0);
    chkn("wd_no_ld_pulse", 83'(ld_cnt), 83'(ld0));
    err_clr = 1'b1;
    cyc;
    err_clr = 1'b0;
    chk1("wd_cleared", timeout, 1'b0);
    do_layer(3, 1'b1);
    cyc;

    // s_fin on the last watchdog cycle completes normally.
    push(mkd(1'b0, 4'd7, 5'd8, 5'd6, 8'h70), 1'b1);
    do_layer(15, 1'b1);
    chk1("edge_no_timeout", timeout, 1'b0);
    cyc;
    chk1("edge_no_timeout_later", timeout, 1'b0);

    // Stray s_fin in IDLE.
    ld0 = ld_cnt;
    s_fin = 1'b1;
    repeat (3) cyc;
    s_fin = 1'b0;
    chk1("stray_busy", busy, 1'b0);
    chkn("stray_layer_cnt", 83'(layer_cnt), 83'(11));
    chkn("stray_no_ld", 83'(ld_cnt), 83'(ld0));

    // en dropped mid-RUN with two queued behind.
    en = 1'b0;
    for (int i = 0; i < 3; i++) dq[i] = mkd(1'b1, 4'(i + 10), 5'(i + 20), 5'(i + 25), 8'(8'h80 + i));
    push(dq[0], 1'b1);
    push(dq[1], 1'b0);
    push(dq[2], 1'b0);
    ad0 = ad_cnt;
    en = 1'b1;
    wait_sinit;
    en = 1'b0;
    fin_layer(3, 1'b0);
    cyc;
    chk1("enlow_idle", busy, 1'b0);
    chkn("enlow_fifo", 83'(fifo_cnt), 83'(2));
    repeat (2) cyc;
    chk1("enlow_stays_idle", busy, 1'b0);
    chkn("enlow_no_all_done", 83'(ad_cnt), 83'(ad0));

    // Reset mid-RUN.
    exp_q.push_back(dq[1]);
    en = 1'b1;
    wait_sinit;
    repeat (3) cyc;
    rst = 1'b1;
    cyc;
    chk1("rstrun_busy", busy, 1'b0);
    chk1("rstrun_run", run, 1'b0);
    chkn("rstrun_fifo", 83'(fifo_cnt), 83'(0));
    chkn("rstrun_layer_cnt", 83'(layer_cnt), 83'(0));
    chkn("rstrun_cfg", cfg_o, 83'(0));
    chk1("rstrun_ready", cmd_ready, 1'b0);
    rst = 1'b0;
    cyc;
    chk1("rstrun_ready_after", cmd_ready, 1'b1);
    chk1("rstrun_idle", busy, 1'b0);
    push(mkd(1'b0, 4'd4, 5'd5, 5'd6, 8'h90), 1'b1);
    do_layer(2, 1'b1);
    cyc;
    chkn("restart_layer_cnt", 83'(layer_cnt), 83'(1));

    repeat (2) cyc;
    chkn("scoreboard_empty", 83'(exp_q.size()), 83'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
